// File: rtl/bcd_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_seq_ctrl : sequential binary-to-BCD converter (double-dabble),        |
// | one bit per clock, valid/ready on both the operand and result sides.      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module bcd_seq_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] number,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       hundreds,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             busy
);

  localparam int BCDW = 4 * DIGITS;
  localparam int WW   = BCDW + WIDTH;
  localparam int CW   = $clog2(WIDTH + 1);

  localparam logic [1:0]    c_idle  = 2'd0;
  localparam logic [1:0]    c_shift = 2'd1;
  localparam logic [1:0]    c_done  = 2'd2;
  localparam logic [CW-1:0] c_last  = CW'(WIDTH - 1);

  logic [1:0]    r_state;
  logic [WW-1:0] r_work;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_hundreds;
  logic [3:0]    r_tens;
  logic [3:0]    r_ones;

  logic [WW-1:0] w_adj;
  logic [WW-1:0] w_shift;

  // Add-3 correction on every BCD digit that would overflow when doubled.
  always_comb begin
    w_adj = r_work;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_work[WIDTH + 4*d +: 4] >= 4'd5)
        w_adj[WIDTH + 4*d +: 4] = r_work[WIDTH + 4*d +: 4] + 4'd3;
    end
    w_shift = {w_adj[WW-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_idle;
      r_work     <= '0;
      r_cnt      <= '0;
      r_hundreds <= 4'd0;
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
    end else begin
      case (r_state)
        c_idle: begin
          if (in_valid) begin
            r_work  <= {{BCDW{1'b0}}, number};
            r_cnt   <= '0;
            r_state <= c_shift;
          end
        end
        c_shift: begin
          r_work <= w_shift;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == c_last) begin
            r_hundreds <= w_shift[WIDTH + 8 +: 4];
            r_tens     <= w_shift[WIDTH + 4 +: 4];
            r_ones     <= w_shift[WIDTH +: 4];
            r_state    <= c_done;
          end
        end
        c_done: begin
          if (out_ready)
            r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign in_ready  = (r_state == c_idle);
  assign out_valid = (r_state == c_done);
  assign busy      = (r_state != c_idle);
  assign hundreds  = r_hundreds;
  assign tens      = r_tens;
  assign ones      = r_ones;

endmodule
`default_nettype wire
